dot_vec_loader_8: RTL and testbench
===================================

Name: dot_vec_loader_8

Overview:
Upstream feeder for the 8-lane, 8-bit dot-product datapath. It accepts (a, b) element pairs one per beat over a valid/ready stream and packs them into vec_a/vec_b lane by lane. It issues a one-cycle compute pulse when a vector is complete, either after LANES beats or early on in_last. It then holds its vectors stable and stalls the stream until the datapath has had DP_LATENCY cycles to produce its result.

Parameters:
LANES, 8, elements per vector; fixed at 8 for this datapath.
ELEM_W, 8, element width in bits.
DP_LATENCY, 2, cycles from the compute-sampling edge to the datapath result being registered; also the WAIT length.
CNT_W, 16, width of the issued-vector counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream beat valid
in_ready  out  1  loader can accept a beat
in_a  in  ELEM_W  element for vec_a
in_b  in  ELEM_W  element for vec_b
in_last  in  1  final element of the current vector
vec_a  out  LANES*ELEM_W  packed vector A; lane i at bits [i*8+7:i*8]
vec_b  out  LANES*ELEM_W  packed vector B, same lane layout
compute  out  1  one-cycle issue strobe to the datapath
vec_len  out  4  number of valid lanes in the issued vector, 1..8
busy  out  1  high in ISSUE and WAIT
vec_count  out  CNT_W  vectors issued since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=FILL, lane index=0, wait counter=0.
  - vec_a=0, vec_b=0, compute=0, vec_len=0, vec_count=0, busy=0.
  - in_ready=1 as soon as reset is released.
- States are FILL, ISSUE and WAIT.
- FILL:
  - in_ready=1, busy=0.
  - A beat is accepted on a rising edge when in_valid=1 and in_ready=1.
  - An accepted beat writes in_a/in_b into lane idx, then idx increments.
  - On the beat where idx==LANES-1 or in_last=1: go to ISSUE, capture vec_len=idx+1, and reset idx to 0.
  - in_last on the 8th beat behaves exactly like a plain 8th beat.
- Short vectors:
  - Lanes not written in the current vector read as 0; the buffer is cleared on entry to FILL.
  - This gives zero contribution to the dot product.
- ISSUE (exactly 1 cycle):
  - compute=1 and is a registered output. in_ready=0, busy=1.
  - vec_count increments on the exiting edge.
  - Next state is WAIT.
- WAIT (exactly DP_LATENCY cycles):
  - in_ready=0, busy=1.
  - vec_a, vec_b and vec_len are held unchanged.
  - On the final WAIT edge: clear vec_a/vec_b to 0 and go to FILL.
  - vec_len holds its value until the next issue.
- Latency and throughput:
  - compute is high in the cycle after the edge that accepts the last beat.
  - Minimum period is LANES + 1 + DP_LATENCY = 11 cycles per full vector at default parameters.
- Stream rules:
  - A beat presented while in_ready=0 is not consumed. The source must hold the beat until it is accepted.
  - Gaps (in_valid=0) in FILL leave idx and the buffer unchanged.
- Vectors only change in FILL or on reset. They never change while compute=1 or during WAIT.
- Reset mid-operation in any state aborts the partial vector. No compute is generated for it and vec_count is not affected beyond its reset to 0.
- vec_count wraps from 2^CNT_W-1 to 0 with no flag.
- Arithmetic: idx is 3 bits and vec_len is 4 bits. No other arithmetic is performed; the datapath owns the products and sums.

Decomposition:
- Shared package dot_product_pkg:
  - Constants LANES=8, ELEM_W=8, PROD_W=16, RESULT_W=19.
  - Packed type vec_t = logic [LANES-1:0][ELEM_W-1:0].
  - Enum loader_state_t {FILL, ISSUE, WAIT}.
- No sub-module: a single FSM plus lane buffer. The top-level wrapper instantiates this block beside the datapath, with compute wired across.

Test Plan:
1. Reset, then idle with in_valid=0 -> all outputs 0, in_ready=1, no compute pulse for 20 cycles.
2. Eight back-to-back beats, a=1..8, b=2 -> compute high for one cycle, 1 cycle after the 8th accept. vec_a=64'h0807060504030201, vec_b=64'h0202020202020202, vec_len=8, vec_count=1. in_ready low for exactly 3 cycles, then FILL.
3. Full vector of all 0xFF, then a short vector a=5,6,7, b=1 with in_last on beat 3:
   - Second issue: vec_a=64'h0000000000070605, vec_b=64'h0000000000010101, vec_len=3.
   - Upper lanes read 0, with no residue from the 0xFF vector.
4. Source holds in_valid=1 continuously across ISSUE/WAIT with changing data -> only beats accepted in FILL appear in the next vector, in order, with none lost or duplicated. Random in_valid gaps give identical vectors.
5. Assert rst_n low asynchronously after 4 of 8 beats, release, then send 8 fresh beats -> no compute for the aborted vector. Next vector contains only the fresh beats, vec_count=1.
6. CNT_W=4, issue 17 one-beat vectors, a=k, b=1 -> vec_count reads 0 after the 16th issue and 1 after the 17th. vec_len=1 each time, with vec_a lane 0 = k.

Source files
------------

// File: rtl/dot_product_pkg.sv
// ---------------------------------------------------------------------------
// dot_product_pkg
// Shared definitions for the 8-lane, 8-bit dot-product datapath and its
// vector loader: lane geometry, result widths, the packed vector type and
// the loader FSM state encoding.
// ---------------------------------------------------------------------------
package dot_product_pkg;

  localparam int LANES    = 8;
  localparam int ELEM_W   = 8;
  localparam int PROD_W   = 16;
  localparam int RESULT_W = 19;

  // Lane i occupies bits [i*ELEM_W +: ELEM_W] when flattened.
  typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } loader_state_t;

endpackage : dot_product_pkg

// File: rtl/dot_vec_loader_8.sv
// ---------------------------------------------------------------------------
// dot_vec_loader_8
// Packs (a, b) element pairs arriving on a valid/ready stream into two
// 8-lane vectors, pulses compute for one cycle when a vector is complete
// (8 beats or in_last), then holds the vectors and stalls the stream for
// DP_LATENCY cycles while the datapath produces its result.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream beat valid
//   in_ready   out  loader can accept a beat (FILL only)
//   in_a/in_b  in   elements for vec_a / vec_b
//   in_last    in   final element of the current vector
//   vec_a/b    out  packed vectors, lane i at bits [i*8+7:i*8]
//   compute    out  one-cycle issue strobe
//   vec_len    out  valid lanes in the issued vector (1..8)
//   busy       out  high in ISSUE and WAIT
//   vec_count  out  vectors issued since reset, wraps
// ---------------------------------------------------------------------------
module dot_vec_loader_8
  import dot_product_pkg::*;
#(
  parameter int DP_LATENCY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ELEM_W-1:0]       in_a,
  input  logic [ELEM_W-1:0]       in_b,
  input  logic                    in_last,
  output logic [LANES*ELEM_W-1:0] vec_a,
  output logic [LANES*ELEM_W-1:0] vec_b,
  output logic                    compute,
  output logic [3:0]              vec_len,
  output logic                    busy,
  output logic [CNT_W-1:0]        vec_count
);

  localparam int WAIT_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DP_LATENCY - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(LANES - 1);

  loader_state_t     r_state;
  logic [2:0]        r_idx;
  logic [WAIT_W-1:0] r_wait_cnt;
  vec_t              r_vec_a;
  vec_t              r_vec_b;
  logic              r_compute;
  logic [3:0]        r_vec_len;
  logic              r_busy;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_vec_count;

  logic              w_accept;

  // in_ready is only ever high in FILL, so this is the FILL-state handshake.
  assign w_accept = in_valid & r_in_ready;

  // Loader FSM, lane buffer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_idx       <= 3'd0;
      r_wait_cnt  <= '0;
      r_vec_a     <= '0;
      r_vec_b     <= '0;
      r_compute   <= 1'b0;
      r_vec_len   <= 4'd0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_vec_count <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_vec_a[r_idx] <= in_a;
            r_vec_b[r_idx] <= in_b;
            // in_last on the final lane is indistinguishable from a full vector.
            if ((r_idx == IDX_LAST) || in_last) begin
              r_state    <= ISSUE;
              r_vec_len  <= {1'b0, r_idx} + 4'd1;
              r_idx      <= 3'd0;
              r_compute  <= 1'b1;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ISSUE: begin
          r_compute   <= 1'b0;
          r_vec_count <= r_vec_count + {{(CNT_W-1){1'b0}}, 1'b1};
          r_wait_cnt  <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            // Clearing here means short vectors see zeros in unwritten lanes.
            r_vec_a    <= '0;
            r_vec_b    <= '0;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= FILL;
          end else begin
            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state    <= FILL;
          r_idx      <= 3'd0;
          r_wait_cnt <= '0;
          r_vec_a    <= '0;
          r_vec_b    <= '0;
          r_compute  <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign vec_a     = r_vec_a;
  assign vec_b     = r_vec_b;
  assign compute   = r_compute;
  assign vec_len   = r_vec_len;
  assign busy      = r_busy;
  assign vec_count = r_vec_count;

endmodule : dot_vec_loader_8

// File: tb/tb_dot_vec_loader_8.sv
// ---------------------------------------------------------------------------
// tb_dot_vec_loader_8
// Self-checking bench for dot_vec_loader_8. A reference model splits the
// beat sequence into vectors (8 beats or in_last) and compares each issued
// vector; a second instance with a 4-bit counter checks counter wrap.
// ---------------------------------------------------------------------------
module tb_dot_vec_loader_8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic        in_last = 1'b0;
  logic [63:0] vec_a;
  logic [63:0] vec_b;
  logic        compute;
  logic [3:0]  vec_len;
  logic        busy;
  logic [15:0] vec_count;

  logic        d4_valid = 1'b0;
  logic        d4_ready;
  logic [7:0]  d4_a = 8'd0;
  logic [7:0]  d4_b = 8'd0;
  logic        d4_last = 1'b0;
  logic [63:0] d4_vec_a;
  logic [63:0] d4_vec_b;
  logic        d4_compute;
  logic [3:0]  d4_vec_len;
  logic        d4_busy;
  logic [3:0]  d4_vec_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          compute_seen = 0;
  logic [15:0] exp_count = 16'd0;

  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  bit          q_l[$];
  logic [63:0] last_a;
  logic [63:0] last_b;
  logic [3:0]  last_len;

  dot_vec_loader_8 #(.DP_LATENCY(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .vec_a(vec_a), .vec_b(vec_b),
    .compute(compute), .vec_len(vec_len), .busy(busy), .vec_count(vec_count)
  );

  dot_vec_loader_8 #(.DP_LATENCY(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(d4_valid), .in_ready(d4_ready),
    .in_a(d4_a), .in_b(d4_b), .in_last(d4_last), .vec_a(d4_vec_a), .vec_b(d4_vec_b),
    .compute(d4_compute), .vec_len(d4_vec_len), .busy(d4_busy), .vec_count(d4_vec_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (compute === 1'b1) compute_seen++;
  end

  // Drive the queued beats, check every issued vector against the model.
  task automatic run_stream(input bit gap_en, input bit hold_junk);
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];
    int          exp_len_q[$];
    logic [63:0] va, vb;
    int          n, ptr, budget;
    bit          drv_real, done;
    logic [63:0] ea, eb;
    int          el;
    // Model: vectors close after 8 elements or on last; unused lanes are 0.
    va = 64'd0; vb = 64'd0; n = 0;
    for (int i = 0; i < q_a.size(); i++) begin
      va[n*8 +: 8] = q_a[i];
      vb[n*8 +: 8] = q_b[i];
      n++;
      if (n == 8 || q_l[i]) begin
        exp_a_q.push_back(va); exp_b_q.push_back(vb); exp_len_q.push_back(n);
        va = 64'd0; vb = 64'd0; n = 0;
      end
    end
    ptr = 0; budget = 0; drv_real = 1'b0; done = 1'b0;
    while (!done && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (drv_real) ptr++;
      drv_real = 1'b0;
      if (compute === 1'b1) begin
        n_checks++;
        if (exp_a_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra_compute: got compute=1 required no issue pending");
        end else begin
          ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front(); el = exp_len_q.pop_front();
          if (vec_a !== ea || vec_b !== eb || vec_len !== 4'(el) || vec_count !== exp_count) begin
            n_fail++;
            $display("FAIL stream_vector: got a=%h b=%h len=%0d cnt=%0d required a=%h b=%h len=%0d cnt=%0d",
                     vec_a, vec_b, vec_len, vec_count, ea, eb, el, exp_count);
          end
          exp_count = exp_count + 16'd1;
          last_a = vec_a; last_b = vec_b; last_len = vec_len;
        end
      end
      if (ptr == q_a.size() && exp_a_q.size() == 0 && in_ready === 1'b1) begin
        done = 1'b1;
        in_valid = 1'b0;
      end else if (in_ready === 1'b1) begin
        if (ptr < q_a.size() && !(gap_en && $urandom_range(0, 2) == 0)) begin
          in_valid = 1'b1; in_a = q_a[ptr]; in_b = q_b[ptr]; in_last = q_l[ptr];
          drv_real = 1'b1;
        end else begin
          in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
        end
      end else if (hold_junk) begin
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats accepted, %0d vectors pending, required all done",
               ptr, exp_a_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (vec_a !== 64'd0 || vec_b !== 64'd0 || compute !== 1'b0 || vec_len !== 4'd0 ||
        vec_count !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got a=%h b=%h c=%b len=%0d cnt=%0d busy=%b required all 0",
               vec_a, vec_b, compute, vec_len, vec_count, busy);
    end
    rst_n = 1'b1;
    exp_count = 16'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (compute !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || vec_a !== 64'd0 ||
          vec_len !== 4'd0 || vec_count !== 16'd0) begin
        n_fail++;
        $display("FAIL idle_cycle_%0d: got c=%b rdy=%b busy=%b a=%h len=%0d cnt=%0d required c=0 rdy=1 rest 0",
                 i, compute, in_ready, busy, vec_a, vec_len, vec_count);
      end
    end
  endtask

  task automatic test_full_vector();
    int low_cycles;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_ready_beat_%0d: got in_ready=%b required 1", k, in_ready);
      end
      in_valid = 1'b1; in_a = 8'(k); in_b = 8'd2; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (compute !== 1'b1 || vec_a !== 64'h0807060504030201 || vec_b !== 64'h0202020202020202 ||
        vec_len !== 4'd8 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_issue: got c=%b a=%h b=%h len=%0d busy=%b rdy=%b required c=1 a=0807060504030201 b=0202020202020202 len=8 busy=1 rdy=0",
               compute, vec_a, vec_b, vec_len, busy, in_ready);
    end
    low_cycles = 1;
    @(negedge clk);
    n_checks++;
    if (compute !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pulse_width: got compute=%b in second cycle required 0", compute);
    end
    while (in_ready === 1'b0 && low_cycles < 10) begin
      low_cycles++;
      n_checks++;
      if (vec_a !== 64'h0807060504030201 || vec_len !== 4'd8 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold: got a=%h len=%0d busy=%b required held vector, busy=1",
                 vec_a, vec_len, busy);
      end
      @(negedge clk);
    end
    n_checks++;
    if (low_cycles !== 3) begin
      n_fail++;
      $display("FAIL full_stall_len: got %0d not-ready cycles required 3", low_cycles);
    end
    n_checks++;
    if (vec_count !== 16'd1 || vec_a !== 64'd0 || vec_len !== 4'd8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after: got cnt=%0d a=%h len=%0d busy=%b required cnt=1 a=0 len=8 busy=0",
               vec_count, vec_a, vec_len, busy);
    end
    exp_count = 16'd1;
  endtask

  task automatic test_short_vector();
    q_a.delete(); q_b.delete(); q_l.delete();
    for (int i = 0; i < 8; i++) begin
      q_a.push_back(8'hFF); q_b.push_back(8'hFF); q_l.push_back(1'b0);
    end
    for (int i = 5; i <= 7; i++) begin
      q_a.push_back(8'(i)); q_b.push_back(8'd1); q_l.push_back(i == 7);
    end
    run_stream(1'b0, 1'b0);
    n_checks++;
    if (last_a !== 64'h0000000000070605 || last_b !== 64'h0000000000010101 || last_len !== 4'd3) begin
      n_fail++;
      $display("FAIL short_vector: got a=%h b=%h len=%0d required a=0000000000070605 b=0000000000010101 len=3",
               last_a, last_b, last_len);
    end
  endtask

  task automatic test_stall_hold();
    q_a.delete(); q_b.delete(); q_l.delete();
    for (int i = 0; i < 30; i++) begin
      q_a.push_back(8'($urandom)); q_b.push_back(8'($urandom));
      q_l.push_back(($urandom_range(0, 5) == 0) || (i == 29));
    end
    run_stream(1'b0, 1'b1);
    run_stream(1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    int seen_before;
    seen_before = compute_seen;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (vec_a !== 64'd0 || vec_b !== 64'd0 || vec_count !== 16'd0 || busy !== 1'b0 || compute !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async_reset: got a=%h b=%h cnt=%0d busy=%b c=%b required all 0",
               vec_a, vec_b, vec_count, busy, compute);
    end
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    exp_count = 16'd0;
    q_a.delete(); q_b.delete(); q_l.delete();
    for (int i = 0; i < 8; i++) begin
      q_a.push_back(8'($urandom)); q_b.push_back(8'($urandom)); q_l.push_back(1'b0);
    end
    run_stream(1'b0, 1'b0);
    n_checks++;
    if (compute_seen - seen_before !== 1 || vec_count !== 16'd1) begin
      n_fail++;
      $display("FAIL abort_counts: got %0d issues cnt=%0d required 1 issue cnt=1",
               compute_seen - seen_before, vec_count);
    end
  endtask

  task automatic test_wrap();
    int guard;
    for (int k = 1; k <= 17; k++) begin
      guard = 0;
      @(negedge clk);
      while (d4_ready !== 1'b1 && guard < 10) begin
        guard++;
        @(negedge clk);
      end
      d4_valid = 1'b1; d4_a = 8'(k); d4_b = 8'd1; d4_last = 1'b1;
      @(negedge clk);
      d4_valid = 1'b0; d4_last = 1'b0;
      n_checks++;
      if (d4_compute !== 1'b1 || d4_vec_a !== {56'd0, 8'(k)} || d4_vec_b !== 64'd1 || d4_vec_len !== 4'd1) begin
        n_fail++;
        $display("FAIL wrap_issue_%0d: got c=%b a=%h b=%h len=%0d required c=1 a=%h b=1 len=1",
                 k, d4_compute, d4_vec_a, d4_vec_b, d4_vec_len, {56'd0, 8'(k)});
      end
      guard = 0;
      while (d4_ready !== 1'b1 && guard < 10) begin
        guard++;
        @(negedge clk);
      end
      n_checks++;
      if (d4_vec_count !== 4'(k % 16) || d4_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_count_%0d: got cnt=%0d rdy=%b required cnt=%0d rdy=1",
                 k, d4_vec_count, d4_ready, k % 16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_short_vector();
    test_stall_hold();
    test_reset_abort();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dot_vec_loader_8
